// File: rtl/sm_fetch.sv
// Instruction fetch stage: owns the fetch PC, drives the combinational ROM address and
// buffers {pc, instr} pairs in a small prefetch queue feeding the decoder via valid/ready.
module sm_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imAddr,
    input  logic [31:0] imData,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          pop;
    logic          push;

    assign out_valid = (count != '0);
    assign out_instr = instr_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];
    assign imAddr    = {2'b00, fetch_pc[31:2]};

    // A pop frees a slot in the same cycle, so a full queue still accepts a fetch.
    assign pop  = out_valid & out_ready;
    assign push = !redirect & ((count < FULL) | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]    <= fetch_pc;
                instr_q[wr_ptr] <= imData;
                wr_ptr          <= wr_ptr + 1'b1;
                fetch_pc        <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sm_fetch.sv
// Bench for sm_fetch: directed scenarios against hand-derived constants, then a randomized
// run against a queue-based reference model. ROM word i holds 0x1000_0000 + i.
module tb_sm_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imAddr;
    logic [31:0] imData;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    sm_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imAddr     (imAddr),
        .imData     (imData),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    assign imData = 32'h1000_0000 + imAddr;

    function automatic logic [31:0] rom(input logic [31:0] pc);
        return 32'h1000_0000 + {2'b00, pc[31:2]};
    endfunction

    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        redirect  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        total++; if (imAddr !== 32'h0) begin bad++; $display("FAIL reset_imaddr: got %h want 0", imAddr); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            total++; if (out_pc !== 32'(4*i)) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, 32'(4*i)); end
            total++; if (out_instr !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, 32'h1000_0000 + 32'(i)); end
            total++; if (imAddr !== 32'(i+1)) begin bad++; $display("FAIL stream_imaddr[%0d]: got %h want %h", i, imAddr, 32'(i+1)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int j = 1; j <= 5; j++) begin
            step(1'b0, 32'h0, 1'b0);
            total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000_0000) begin
                bad++; $display("FAIL stall_head[%0d]: got v=%b pc=%h instr=%h want v=1 pc=0 instr=10000000", j, out_valid, out_pc, out_instr);
            end
            total++; if (imAddr !== ((j < 2) ? 32'(j) : 32'h2)) begin
                bad++; $display("FAIL stall_imaddr[%0d]: got %h want %h", j, imAddr, (j < 2) ? 32'(j) : 32'h2);
            end
        end
        // first release edge pops a full queue and pushes 0x8 in the same cycle
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 32'h0, 1'b1);
            total++; if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_instr !== 32'h1000_0000 + 32'(k)) begin
                bad++; $display("FAIL drain_head[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h", k, out_valid, out_pc, out_instr, 32'(4*k));
            end
            total++; if (imAddr !== 32'(2+k)) begin bad++; $display("FAIL drain_imaddr[%0d]: got %h want %h", k, imAddr, 32'(2+k)); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h26, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid: got %b want 0", out_valid); end
        total++; if (imAddr !== 32'h9) begin bad++; $display("FAIL redir_imaddr: got %h want 9", imAddr); end
        step(1'b0, 32'h0, 1'b0);
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h24 || out_instr !== 32'h1000_0009) begin
            bad++; $display("FAIL redir_head: got v=%b pc=%h instr=%h want v=1 pc=24 instr=10000009", out_valid, out_pc, out_instr);
        end
        total++; if (imAddr !== 32'hA) begin bad++; $display("FAIL redir_next_imaddr: got %h want a", imAddr); end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        for (int b = 0; b < 3; b++) begin
            step(1'b1, 32'h100, 1'b1);
            total++; if (out_valid !== 1'b0 || imAddr !== 32'h40) begin
                bad++; $display("FAIL hold_bubble[%0d]: got v=%b imaddr=%h want v=0 imaddr=40", b, out_valid, imAddr);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 1'b1);
            total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4*k) || out_instr !== 32'h1000_0040 + 32'(k)) begin
                bad++; $display("FAIL hold_resume[%0d]: got v=%b pc=%h instr=%h want pc=%h", k, out_valid, out_pc, out_instr, 32'h100 + 32'(4*k));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || imAddr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            bad++; $display("FAIL async_rst: got v=%b imaddr=%h pc=%h instr=%h want all 0", out_valid, imAddr, out_pc, out_instr);
        end
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 32'h0, 1'b1);
            total++; if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_instr !== 32'h1000_0000 + 32'(k)) begin
                bad++; $display("FAIL async_restart[%0d]: got v=%b pc=%h instr=%h want pc=%h", k, out_valid, out_pc, out_instr, 32'(4*k));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        do_reset();
        step(1'b1, 32'hFFFF_FFF9, 1'b1);
        total++; if (imAddr !== 32'h3FFF_FFFE) begin bad++; $display("FAIL wrap_imaddr: got %h want 3ffffffe", imAddr); end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 1'b1);
            total++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k] || out_instr !== rom(exp_pc[k])) begin
                bad++; $display("FAIL wrap_head[%0d]: got v=%b pc=%h instr=%h want pc=%h", k, out_valid, out_pc, out_instr, exp_pc[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] mq [$];
        logic [31:0] mpc;
        logic        rd;
        logic        rdy;
        logic        mpop;
        logic        mpush;
        logic [31:0] rpc;
        do_reset();
        mq.delete();
        mpc = 32'h0;
        for (int n = 0; n < 400; n++) begin
            rd    = ($urandom_range(0, 19) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            rpc   = $urandom;
            mpop  = (mq.size() != 0) && rdy;
            mpush = !rd && ((mq.size() < DEPTH) || mpop);
            step(rd, rpc, rdy);
            if (rd) begin
                mq.delete();
                mpc = rpc & ~32'h3;
            end else begin
                if (mpop) void'(mq.pop_front());
                if (mpush) begin
                    mq.push_back({mpc, rom(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
            total++; if (out_valid !== (mq.size() != 0)) begin
                bad++; $display("FAIL rand_valid[%0d]: got %b want %b", n, out_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                total++; if ({out_pc, out_instr} !== mq[0]) begin
                    bad++; $display("FAIL rand_head[%0d]: got %h/%h want %h/%h", n, out_pc, out_instr, mq[0][63:32], mq[0][31:0]);
                end
            end
            total++; if (imAddr !== {2'b00, mpc[31:2]}) begin
                bad++; $display("FAIL rand_imaddr[%0d]: got %h want %h", n, imAddr, {2'b00, mpc[31:2]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_hold();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
